instr_decode_seq: RTL and testbench

INSTR_DECODE_SEQ -- requirements
Module: instr_decode_seq

---
 rtl/instr_decode_seq.sv | 160 ++++++++++++++++
 tb/tb_instr_decode_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_seq.sv
// Instruction decode sequencer: registered strobes, multi-cycle MUL and LD_M.
// Define DECODE_ILLEGAL_TRAP_EN to flag reserved opcodes 100x on illegal_op.
module instr_decode_seq #(
    parameter int INSTR_W    = 16,
    parameter int DATA_W     = 8,
    parameter int MEM_AW     = 10,
    parameter int REG_AW     = 3,
    parameter int MUL_LAT    = 4,
    parameter int MEM_RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic [3:0]         operation_code,
    output logic               aku_enable,
    output logic               aku_mul_enable,
    output logic               reg_ce,
    output logic [REG_AW-1:0]  register_addr,
    output logic [MEM_AW-1:0]  mem_adr,
    output logic               mem_wr,
    output logic               mem_rd,
    output logic               direct_load,
    output logic [DATA_W-1:0]  direct_data,
    output logic               busy,
    output logic               illegal_op
);

    localparam int MAX_LAT = (MUL_LAT > MEM_RD_LAT) ? MUL_LAT : MEM_RD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [3:0] OP_NOP = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, MEMRD} state_t;

    typedef struct packed {
        logic               aku;
        logic               mul;
        logic               rce;
        logic [REG_AW-1:0]  ra;
        logic [MEM_AW-1:0]  ma;
        logic               wr;
        logic               rd;
        logic               dl;
        logic [DATA_W-1:0]  dd;
        logic               busy;
    } out_t;

    state_t             state, d_state;
    logic [CNT_W-1:0]   cnt, d_cnt;
    logic [INSTR_W-1:0] ir;
    out_t               q, d;
    logic [3:0]         op;
    logic               imm;
    logic               accept;
    logic [REG_AW-1:0]  opnd_ra;
    logic [DATA_W-1:0]  opnd_dd;

    assign op      = instruction[INSTR_W-1 -: 4];
    assign imm     = instruction[8];
    assign opnd_ra = imm ? '0 : instruction[REG_AW-1:0];
    assign opnd_dd = imm ? instruction[DATA_W-1:0] : '0;

    // Ready in the last cycle of a multi-cycle op keeps back-to-back issue gap-free
    assign instr_ready = (state == IDLE) || (state == EXEC) || (cnt == '0);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        d       = '0;
        d_state = EXEC;
        d_cnt   = '0;
        unique case (1'b1)
            (op <= 4'd5): begin
                d.aku = 1'b1;
                d.ra  = opnd_ra;
                d.dl  = imm;
                d.dd  = opnd_dd;
            end
            (op == 4'b0111): begin
                d.mul   = 1'b1;
                d.ra    = opnd_ra;
                d.dl    = imm;
                d.dd    = opnd_dd;
                d.busy  = 1'b1;
                d_state = MUL;
                d_cnt   = CNT_W'(MUL_LAT - 1);
            end
            (op[3:1] == 3'b101): begin
                d.rd    = 1'b1;
                d.ma    = instruction[MEM_AW-1:0];
                d.aku   = (MEM_RD_LAT == 1);
                d.busy  = 1'b1;
                d_state = MEMRD;
                d_cnt   = CNT_W'(MEM_RD_LAT - 1);
            end
            (op[3:1] == 3'b110): begin
                d.aku = imm;
                d.dl  = imm;
                d.dd  = opnd_dd;
                d.rce = !imm;
                d.ra  = opnd_ra;
            end
            (op[3:1] == 3'b111): begin
                d.wr = 1'b1;
                d.ma = instruction[MEM_AW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ir    <= '0;
            q     <= '0;
        end else if (accept) begin
            state <= d_state;
            cnt   <= d_cnt;
            ir    <= instruction;
            q     <= d;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (state == MEMRD && cnt == CNT_W'(1))
                q.aku <= 1'b1;
        end else begin
            state <= IDLE;
            q     <= '0;
        end
    end

    assign operation_code = (state == IDLE) ? OP_NOP : ir[INSTR_W-1 -: 4];
    assign aku_enable     = q.aku;
    assign aku_mul_enable = q.mul;
    assign reg_ce         = q.rce;
    assign register_addr  = q.ra;
    assign mem_adr        = q.ma;
    assign mem_wr         = q.wr;
    assign mem_rd         = q.rd;
    assign direct_load    = q.dl;
    assign direct_data    = q.dd;
    assign busy           = q.busy;

    logic unused_ir;
    assign unused_ir = ^ir[INSTR_W-5:0];

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ill_q <= 1'b0;
        else if (accept && op[3:1] == 3'b100)
            ill_q <= 1'b1;
    end
    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_seq.sv
// Scoreboard bench for instr_decode_seq with a per-cycle reference model.
module tb_instr_decode_seq;

    localparam int MUL_LAT    = 4;
    localparam int MEM_RD_LAT = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instruction = '0;
    logic        instr_ready;
    logic [3:0]  operation_code;
    logic        aku_enable, aku_mul_enable, reg_ce;
    logic [2:0]  register_addr;
    logic [9:0]  mem_adr;
    logic        mem_wr, mem_rd, direct_load;
    logic [7:0]  direct_data;
    logic        busy, illegal_op;

    always #5 clk = ~clk;

    instr_decode_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .operation_code(operation_code),
        .aku_enable(aku_enable), .aku_mul_enable(aku_mul_enable),
        .reg_ce(reg_ce), .register_addr(register_addr),
        .mem_adr(mem_adr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .direct_load(direct_load), .direct_data(direct_data),
        .busy(busy), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic [3:0] op;
        logic       aku, mul, rce;
        logic [2:0] ra;
        logic [9:0] ma;
        logic       wr, rd, dl;
        logic [7:0] dd;
        logic       busy, rdy, ill;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic trap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   sticky = 1'b0;

    function automatic vec_t idle_vec();
        vec_t v = '0;
        v.op  = 4'b0110;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t act();
        vec_t a;
        a.op = operation_code; a.aku = aku_enable; a.mul = aku_mul_enable;
        a.rce = reg_ce; a.ra = register_addr; a.ma = mem_adr;
        a.wr = mem_wr; a.rd = mem_rd; a.dl = direct_load;
        a.dd = direct_data; a.busy = busy; a.rdy = instr_ready;
        a.ill = illegal_op;
        return a;
    endfunction

    // Expected output sequence of one instruction, one entry per cycle
    task automatic push_exp(input logic [15:0] ins);
        int   op, n;
        bit   imm, multi;
        exp_t e;
        op    = int'(ins[15:12]);
        imm   = ins[8];
        multi = (op == 7) || (op == 10) || (op == 11);
        n     = (op == 7) ? MUL_LAT : (multi ? MEM_RD_LAT : 1);
        for (int i = 0; i < n; i++) begin
            e       = '0;
            e.v.op  = ins[15:12];
            e.v.rdy = (i == n - 1);
            e.v.busy = multi;
            if (op <= 5 || op == 7) begin
                if (op == 7) e.v.mul = 1'b1;
                else e.v.aku = 1'b1;
                if (imm) begin
                    e.v.dl = 1'b1;
                    e.v.dd = ins[7:0];
                end else begin
                    e.v.ra = ins[2:0];
                end
            end else if (op == 8 || op == 9) begin
                e.trap = TRAP;
            end else if (op == 10 || op == 11) begin
                e.v.rd  = 1'b1;
                e.v.ma  = ins[9:0];
                e.v.aku = (i == n - 1);
            end else if (op == 12 || op == 13) begin
                if (imm) begin
                    e.v.aku = 1'b1;
                    e.v.dl  = 1'b1;
                    e.v.dd  = ins[7:0];
                end else begin
                    e.v.rce = 1'b1;
                    e.v.ra  = ins[2:0];
                end
            end else if (op >= 14) begin
                e.v.wr = 1'b1;
                e.v.ma = ins[9:0];
            end
            q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        vec_t a;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en && rst_n) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                end else begin
                    e.v    = idle_vec();
                    e.trap = 1'b0;
                end
                if (e.trap) sticky = 1'b1;
                e.v.ill = sticky;
                a = act();
                total++;
                if (a !== e.v) begin
                    bad++;
                    $display("FAIL cyc t=%0t got=%h exp=%h", $time, a, e.v);
                end
            end
        end
    end

    task automatic chk(input string name, input vec_t got, input vec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] ins);
        bit done = 1'b0;
        instr_valid = 1'b1;
        instruction = ins;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (instr_ready) begin
                push_exp(ins);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        instruction = 16'($urandom);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout ins=%h got_ready=%b exp_ready=1",
                     ins, instr_ready);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            instr_valid = 1'b0;
            instruction = 16'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        #1 rst_n = 1'b0;
        #3 chk("reset", act(), idle_vec());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        send(16'h0105); idle(2);
        send(16'h7003); idle(2);
        send(16'hA12C); send(16'hE3FF); idle(2);
        send(16'h8000); idle(3);
        repeat (300) begin
            send(16'($urandom));
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);

        // Reset in the second MUL cycle
        mon_en = 1'b0;
        instr_valid = 1'b1;
        instruction = 16'h7003;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1;
        v = idle_vec();
        v.op = 4'h7; v.mul = 1'b1; v.ra = 3'd3; v.busy = 1'b1; v.rdy = 1'b0;
        v.ill = TRAP ? illegal_op : 1'b0;
        chk("mul_cycle2", act(), v);
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_mul", act(), idle_vec());
        q.delete();
        sticky = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #2 chk("post_reset", act(), idle_vec());
        end
        mon_en = 1'b1;
        send(16'h7105);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
